// File: rtl/rrat_restore_if.sv
// rrat_restore_if: retire/rename-side signals of the RRAT restore sequencer.
// RESTORE_STATS_EN adds the restore counter and the sticky restart flag.
interface rrat_restore_if #(
  parameter int NUM_PHYS_REGS = 64,
  parameter int NUM_ARCH_REGS = 35
);
  localparam int PW = $clog2(NUM_PHYS_REGS);
  localparam int AW = $clog2(NUM_ARCH_REGS);
  logic          Flush_req_IN;
  logic          Pipe_empty_IN;
  logic [PW-1:0] RRAT_ptr_IN;
  logic [AW-1:0] RRAT_idx_OUT;
  logic          RAT_write_OUT;
  logic [AW-1:0] RAT_arch_OUT;
  logic [PW-1:0] RAT_phys_OUT;
  logic          Flush_OUT;
  logic          Stall_OUT;
  logic          Done_OUT;
`ifdef RESTORE_STATS_EN
  logic [15:0]   Restore_count_OUT;
  logic          Restart_seen_OUT;
`endif
  modport slave (
    input  Flush_req_IN, Pipe_empty_IN, RRAT_ptr_IN,
    output RRAT_idx_OUT, RAT_write_OUT, RAT_arch_OUT, RAT_phys_OUT,
    output Flush_OUT, Stall_OUT, Done_OUT
`ifdef RESTORE_STATS_EN
    , output Restore_count_OUT, Restart_seen_OUT
`endif
  );
  modport master (
    output Flush_req_IN, Pipe_empty_IN, RRAT_ptr_IN,
    input  RRAT_idx_OUT, RAT_write_OUT, RAT_arch_OUT, RAT_phys_OUT,
    input  Flush_OUT, Stall_OUT, Done_OUT
`ifdef RESTORE_STATS_EN
    , input Restore_count_OUT, Restart_seen_OUT
`endif
  );
endinterface

// File: rtl/rrat_restore_ctrl.sv
// rrat_restore_ctrl: flush recovery sequencer (squash, drain, copy RRAT into RAT).
// Optional RESTORE_STATS_EN adds a saturating restore counter and a sticky restart flag.
module rrat_restore_ctrl #(
  parameter int NUM_PHYS_REGS = 64,
  parameter int NUM_ARCH_REGS = 35
) (
  input logic           CLK,
  input logic           RESET,
  rrat_restore_if.slave bus
);
  localparam int AW = $clog2(NUM_ARCH_REGS);
  localparam logic [AW-1:0] LAST = AW'(NUM_ARCH_REGS - 1);
  typedef enum logic [2:0] {IDLE, SQUASH, DRAIN, COPY, DONE} state_t;
  state_t        state_q, state_d;
  logic [AW-1:0] idx_q, idx_d;
  logic          in_copy, restart;
  assign in_copy = state_q == COPY;
  assign restart = in_copy && bus.Flush_req_IN;
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q <= IDLE;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end
  // a flush during COPY restarts recovery and wins over the last-index completion
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    case (state_q)
      IDLE:   state_d = bus.Flush_req_IN ? SQUASH : IDLE;
      SQUASH: state_d = DRAIN;
      DRAIN: begin
        state_d = bus.Pipe_empty_IN ? COPY : DRAIN;
        idx_d   = '0;
      end
      COPY: begin
        state_d = restart ? SQUASH : (idx_q == LAST) ? DONE : COPY;
        idx_d   = (restart || idx_q == LAST) ? '0 : idx_q + 1'b1;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  assign bus.Flush_OUT     = state_q == SQUASH;
  assign bus.Done_OUT      = state_q == DONE;
  assign bus.Stall_OUT     = state_q != IDLE;
  assign bus.RAT_write_OUT = in_copy;
  assign bus.RRAT_idx_OUT  = in_copy ? idx_q : '0;
  assign bus.RAT_arch_OUT  = in_copy ? idx_q : '0;
  assign bus.RAT_phys_OUT  = in_copy ? bus.RRAT_ptr_IN : '0;
`ifdef RESTORE_STATS_EN
  logic [15:0] count_q, count_d;
  logic        seen_q, seen_d;
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      count_q <= '0;
      seen_q  <= 1'b0;
    end else begin
      count_q <= count_d;
      seen_q  <= seen_d;
    end
  end
  always_comb begin
    count_d = (state_q == DONE && count_q != 16'hFFFF) ? count_q + 16'd1 : count_q;
    seen_d  = seen_q || restart;
  end
  assign bus.Restore_count_OUT = count_q;
  assign bus.Restart_seen_OUT  = seen_q;
`endif
endmodule

// File: tb/tb_rrat_restore_ctrl.sv
// tb_rrat_restore_ctrl: directed scenario tests for rrat_restore_ctrl.
// RRAT model returns idx+20; define RESTORE_STATS_EN to also exercise the stats outputs.
module tb_rrat_restore_ctrl;
  localparam int NP = 64;
  localparam int NA = 35;
  logic CLK = 1'b0;
  logic RESET;
  int checks = 0;
  int errors = 0;
  rrat_restore_if #(.NUM_PHYS_REGS(NP), .NUM_ARCH_REGS(NA)) bus ();
  rrat_restore_ctrl #(.NUM_PHYS_REGS(NP), .NUM_ARCH_REGS(NA)) dut (
    .CLK(CLK), .RESET(RESET), .bus(bus.slave)
  );
  always #5 CLK = ~CLK;
  assign bus.RRAT_ptr_IN = 6'(bus.RRAT_idx_OUT + 6'd20);

  function automatic logic [24:0] outs();
    return {bus.Flush_OUT, bus.Stall_OUT, bus.Done_OUT, bus.RAT_write_OUT,
            bus.RRAT_idx_OUT, bus.RAT_arch_OUT, bus.RAT_phys_OUT};
  endfunction

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic wait_done(input int bound);
    int n = 0;
    while (!bus.Done_OUT && n < bound) begin
      step();
      n++;
    end
    checks++;
    if (bus.Done_OUT !== 1'b1) begin
      errors++;
      $display("FAIL wait_done: Done_OUT=%b after %0d cycles, required 1", bus.Done_OUT, n);
    end
    step();
  endtask

  task automatic test_reset();
    RESET = 1'b1;
    bus.Flush_req_IN = 1'b0;
    bus.Pipe_empty_IN = 1'b0;
    #1;
    checks++;
    if (outs() !== '0) begin errors++; $display("FAIL reset_outs: got %h required 0", outs()); end
    repeat (2) @(posedge CLK);
    @(negedge CLK) RESET = 1'b0;
    step();
    checks++;
    if (outs() !== '0) begin errors++; $display("FAIL idle_after_reset: got %h required 0", outs()); end
    bus.Pipe_empty_IN = 1'b1;
    bus.Flush_req_IN = 1'b1;
    step();
    bus.Flush_req_IN = 1'b0;
    step();
    step();
    checks++;
    if (bus.RAT_write_OUT !== 1'b1) begin errors++; $display("FAIL pre_reset_copy: write=%b required 1", bus.RAT_write_OUT); end
    #2 RESET = 1'b1;
    #1;
    checks++;
    if (outs() !== '0) begin errors++; $display("FAIL async_reset_outs: got %h required 0", outs()); end
    @(negedge CLK) RESET = 1'b0;
    step();
    step();
    checks++;
    if ({bus.Stall_OUT, bus.Done_OUT} !== 2'b00) begin
      errors++; $display("FAIL reset_idle: stall/done=%b required 00", {bus.Stall_OUT, bus.Done_OUT});
    end
    bus.Flush_req_IN = 1'b1;
    step();
    bus.Flush_req_IN = 1'b0;
    checks++;
    if ({bus.Flush_OUT, bus.Stall_OUT} !== 2'b11) begin
      errors++; $display("FAIL squash_after_reset: flush/stall=%b required 11", {bus.Flush_OUT, bus.Stall_OUT});
    end
    wait_done(60);
  endtask

  task automatic test_basic();
    logic [5:0] ea, ep;
    logic ef, es, ed, ew;
    bus.Pipe_empty_IN = 1'b1;
    bus.Flush_req_IN = 1'b1;
    step();
    bus.Flush_req_IN = 1'b0;
    for (int c = 1; c <= 40; c++) begin
      ef = (c == 1);
      ew = (c >= 3 && c <= 37);
      ed = (c == 38);
      es = (c <= 38);
      ea = ew ? 6'(c - 3) : 6'd0;
      ep = ew ? 6'(c - 3 + 20) : 6'd0;
      checks++;
      if (outs() !== {ef, es, ed, ew, ea, ea, ep}) begin
        errors++;
        $display("FAIL basic_cycle%0d: got %h required %h", c, outs(), {ef, es, ed, ew, ea, ea, ep});
      end
      if (c < 40) step();
    end
  endtask

  task automatic test_drain();
    int nw = 1;
    bus.Pipe_empty_IN = 1'b0;
    bus.Flush_req_IN = 1'b1;
    step();
    bus.Flush_req_IN = 1'b0;
    checks++;
    if (bus.Flush_OUT !== 1'b1) begin errors++; $display("FAIL drain_squash: flush=%b required 1", bus.Flush_OUT); end
    for (int i = 0; i < 10; i++) begin
      step();
      checks++;
      if ({bus.RAT_write_OUT, bus.Stall_OUT, bus.Flush_OUT} !== 3'b010) begin
        errors++;
        $display("FAIL drain_hold%0d: write/stall/flush=%b required 010", i, {bus.RAT_write_OUT, bus.Stall_OUT, bus.Flush_OUT});
      end
    end
    bus.Pipe_empty_IN = 1'b1;
    step();
    checks++;
    if ({bus.RAT_write_OUT, bus.RAT_arch_OUT, bus.RAT_phys_OUT} !== {1'b1, 6'd0, 6'd20}) begin
      errors++;
      $display("FAIL drain_copy_start: write/arch/phys=%b/%0d/%0d required 1/0/20", bus.RAT_write_OUT, bus.RAT_arch_OUT, bus.RAT_phys_OUT);
    end
    for (int i = 0; i < 50 && !bus.Done_OUT; i++) begin
      step();
      if (bus.RAT_write_OUT) nw++;
    end
    checks++;
    if (nw !== 35 || bus.Done_OUT !== 1'b1) begin
      errors++; $display("FAIL drain_writes: writes=%0d done=%b required 35/1", nw, bus.Done_OUT);
    end
    step();
    checks++;
    if (bus.Stall_OUT !== 1'b0) begin errors++; $display("FAIL drain_stall_drop: stall=%b required 0", bus.Stall_OUT); end
  endtask

  task automatic test_restart();
    int nw = 0;
    int nd = 0;
    int bad = 0;
    bus.Pipe_empty_IN = 1'b1;
    bus.Flush_req_IN = 1'b1;
    step();
    bus.Flush_req_IN = 1'b0;
    repeat (19) step();
    checks++;
    if (bus.RAT_arch_OUT !== 6'd17) begin errors++; $display("FAIL restart_idx: arch=%0d required 17", bus.RAT_arch_OUT); end
    bus.Flush_req_IN = 1'b1;
    step();
    bus.Flush_req_IN = 1'b0;
    checks++;
    if ({bus.Flush_OUT, bus.RAT_write_OUT} !== 2'b10) begin
      errors++; $display("FAIL restart_squash: flush/write=%b required 10", {bus.Flush_OUT, bus.RAT_write_OUT});
    end
    for (int i = 0; i < 60; i++) begin
      step();
      if (bus.RAT_write_OUT) begin
        if (bus.RAT_arch_OUT !== 6'(nw)) bad++;
        nw++;
      end
      if (bus.Done_OUT) nd++;
    end
    checks++;
    if (nw !== 35 || nd !== 1 || bad !== 0) begin
      errors++; $display("FAIL restart_copy: writes=%0d dones=%0d misordered=%0d required 35/1/0", nw, nd, bad);
    end
    checks++;
    if (bus.Stall_OUT !== 1'b0) begin errors++; $display("FAIL restart_idle: stall=%b required 0", bus.Stall_OUT); end
  endtask

  task automatic test_ignored();
    int nf = 0;
    bus.Pipe_empty_IN = 1'b1;
    bus.Flush_req_IN = 1'b1;
    step();
    bus.Flush_req_IN = 1'b0;
    step();
    bus.Flush_req_IN = 1'b1;
    step();
    bus.Flush_req_IN = 1'b0;
    checks++;
    if ({bus.RAT_write_OUT, bus.RAT_arch_OUT} !== {1'b1, 6'd0}) begin
      errors++; $display("FAIL ignored_drain: write/arch=%b/%0d required 1/0", bus.RAT_write_OUT, bus.RAT_arch_OUT);
    end
    for (int c = 3; c <= 40; c++) begin
      if (bus.Flush_OUT) nf++;
      if (c == 38) begin
        checks++;
        if (bus.Done_OUT !== 1'b1) begin errors++; $display("FAIL ignored_done: done=%b required 1", bus.Done_OUT); end
        bus.Flush_req_IN = 1'b1;
      end
      if (c == 39) bus.Flush_req_IN = 1'b0;
      if (c < 40) step();
    end
    checks++;
    if (nf !== 0 || bus.Stall_OUT !== 1'b0) begin
      errors++; $display("FAIL ignored_extra: flush pulses=%0d stall=%b required 0/0", nf, bus.Stall_OUT);
    end
  endtask

`ifdef RESTORE_STATS_EN
  task automatic test_stats();
    RESET = 1'b1;
    #1;
    checks++;
    if ({bus.Restore_count_OUT, bus.Restart_seen_OUT} !== 17'd0) begin
      errors++; $display("FAIL stats_reset: count=%0d seen=%b required 0/0", bus.Restore_count_OUT, bus.Restart_seen_OUT);
    end
    @(negedge CLK) RESET = 1'b0;
    bus.Pipe_empty_IN = 1'b1;
    bus.Flush_req_IN = 1'b1;
    step();
    bus.Flush_req_IN = 1'b0;
    wait_done(60);
    checks++;
    if ({bus.Restore_count_OUT, bus.Restart_seen_OUT} !== {16'd1, 1'b0}) begin
      errors++; $display("FAIL stats_first: count=%0d seen=%b required 1/0", bus.Restore_count_OUT, bus.Restart_seen_OUT);
    end
    bus.Flush_req_IN = 1'b1;
    step();
    bus.Flush_req_IN = 1'b0;
    repeat (4) step();
    bus.Flush_req_IN = 1'b1;
    step();
    bus.Flush_req_IN = 1'b0;
    wait_done(60);
    bus.Flush_req_IN = 1'b1;
    step();
    bus.Flush_req_IN = 1'b0;
    wait_done(60);
    checks++;
    if ({bus.Restore_count_OUT, bus.Restart_seen_OUT} !== {16'd3, 1'b1}) begin
      errors++; $display("FAIL stats_final: count=%0d seen=%b required 3/1", bus.Restore_count_OUT, bus.Restart_seen_OUT);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_drain();
    test_restart();
    test_ignored();
`ifdef RESTORE_STATS_EN
    test_stats();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
